// File: rtl/dmem_io_bridge.sv
// ---------------------------------------------------------------------------
// dmem_io_bridge
//
// Sits between the processor dmem port and the dmem syncram. Ordinary loads
// and stores pass straight through to dmem. Stores that land in a 16-word I/O
// window are diverted into a small circular FIFO instead of dmem. The FIFO
// drains to an output peripheral over a valid/ready handshake, so the
// processor gets memory-mapped output without ever stalling. When the FIFO is
// full, window stores are dropped and counted in a saturating counter.
//
// Optional feature macro: DMEM_IO_STATUS_EN
//   defined   : IO_BASE+4'hF is a status register. Loads there return
//               {drop_count, count, full, empty}. Stores there clear
//               drop_count and are not queued.
//   undefined : every window load returns 0, and +4'hF is an ordinary
//               window store.
//
// Ports
//   clock         in   1       single clock, rising edge
//   reset         in   1       synchronous, active-high
//   proc_address  in   ADDR_W  address from processor
//   proc_data     in   DATA_W  store data from processor
//   proc_wren     in   1       store strobe from processor
//   proc_q        out  DATA_W  load data returned to processor
//   mem_address   out  ADDR_W  to dmem
//   mem_data      out  DATA_W  to dmem
//   mem_wren      out  1       to dmem
//   mem_q         in   DATA_W  from dmem (1-cycle read latency)
//   io_valid      out  1       FIFO head valid
//   io_addr       out  4       head entry window offset
//   io_data       out  DATA_W  head entry store data
//   io_ready      in   1       peripheral accepts head
//   drop_count    out  8       saturating count of stores dropped while full
// ---------------------------------------------------------------------------
module dmem_io_bridge #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = 12'hFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] proc_address,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wren,
  output logic [DATA_W-1:0] proc_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              io_valid,
  output logic [3:0]        io_addr,
  output logic [DATA_W-1:0] io_data,
  input  logic              io_ready,
  output logic [7:0]        drop_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 + DATA_W;

  // Window decode and passthrough
  logic is_io;
  assign is_io       = (proc_address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign mem_address = proc_address;
  assign mem_data    = proc_data;
  assign mem_wren    = proc_wren & ~is_io;

  // FIFO state
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [7:0]         drop_count_reg;
  logic               is_io_reg;
  logic [DATA_W-1:0]  io_rdata_reg;

  logic fifo_full, fifo_empty;
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  logic              push_req;
  logic              drop_clear;
  logic [DATA_W-1:0] io_rdata_next;

`ifdef DMEM_IO_STATUS_EN
  logic              is_status;
  logic [DATA_W-1:0] status_word;

  assign is_status  = is_io & (proc_address[3:0] == 4'hF);
  assign push_req   = proc_wren & is_io & ~is_status;
  assign drop_clear = proc_wren & is_status;

  always_comb begin
    status_word              = '0;
    status_word[15:8]        = drop_count_reg;
    status_word[4 +: CNT_W]  = count_reg;
    status_word[1]           = fifo_full;
    status_word[0]           = fifo_empty;
  end

  assign io_rdata_next = is_status ? status_word : '0;
`else
  assign push_req      = proc_wren & is_io;
  assign drop_clear    = 1'b0;
  assign io_rdata_next = '0;
`endif

  // A pop frees a slot in the same edge, so a full FIFO still accepts a
  // store when the peripheral takes the head at the same time.
  logic pop, push_ok, push_drop;
  assign pop       = io_valid & io_ready;
  assign push_ok   = push_req & (~fifo_full | pop);
  assign push_drop = push_req & ~push_ok;

  // Storage: contents are never reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr_reg] <= {proc_address[3:0], proc_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_reg <= '0;
    end else if (drop_clear) begin
      drop_count_reg <= '0;
    end else if (push_drop && drop_count_reg != 8'hFF) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  // Read path: window decode is delayed one cycle to line up with the
  // syncram's read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      is_io_reg    <= 1'b0;
      io_rdata_reg <= '0;
    end else begin
      is_io_reg    <= is_io;
      io_rdata_reg <= io_rdata_next;
    end
  end

  assign proc_q = is_io_reg ? io_rdata_reg : mem_q;

  // Head of FIFO; no bypass, so a fresh store appears one edge later.
  logic [ENTRY_W-1:0] head_entry;
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign io_valid   = ~fifo_empty;
  assign io_addr    = head_entry[ENTRY_W-1 -: 4];
  assign io_data    = head_entry[DATA_W-1:0];
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_io_bridge
//
// Bench for dmem_io_bridge. A small syncram model feeds mem_q. A reference
// model (queue of pending window stores, drop counter, shadow memory) predicts
// every visible output. Directed scenario tasks cover passthrough, single
// store hold, overflow, full push+pop, reset mid-drain, drop saturation and
// (with DMEM_IO_STATUS_EN) the status register; a randomized task follows.
// ---------------------------------------------------------------------------
module tb_dmem_io_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] proc_address = '0;
  logic [DATA_W-1:0] proc_data = '0;
  logic              proc_wren = 1'b0;
  logic [DATA_W-1:0] proc_q;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              io_valid;
  logic [3:0]        io_addr;
  logic [DATA_W-1:0] io_data;
  logic              io_ready = 1'b0;
  logic [7:0]        drop_count;

  always #5 clock = ~clock;

  dmem_io_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .IO_BASE(12'hFF0)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_address(proc_address), .proc_data(proc_data), .proc_wren(proc_wren),
    .proc_q(proc_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q),
    .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data),
    .io_ready(io_ready), .drop_count(drop_count)
  );

  // Syncram stand-in: self-clears its low 64 words during the opening reset.
  logic [DATA_W-1:0] tb_mem [4096];
  int clr_cnt = 0;
  always @(posedge clock) begin
    if (clr_cnt < 64) begin
      tb_mem[clr_cnt] <= '0;
      clr_cnt <= clr_cnt + 1;
    end else if (mem_wren) begin
      tb_mem[mem_address] <= mem_data;
    end
    mem_q <= tb_mem[mem_address];
  end

  // Reference model
  int          errors = 0;
  int          checks = 0;
  logic [35:0] q_model [$];
  int          drops = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q = '0;
  logic        obs_wren, exp_wren;

  // Drives one cycle and advances the model; leaves time at posedge+1.
  task automatic step(input logic [11:0] a, input logic [31:0] d,
                      input logic w, input logic r, input logic rst);
    logic        in_win, stat, pop, full, acc;
    logic [31:0] rd;
    proc_address = a; proc_data = d; proc_wren = w; io_ready = r; reset = rst;
    #1;
    in_win   = (a[11:4] == 8'hFF);
`ifdef DMEM_IO_STATUS_EN
    stat     = in_win && (a[3:0] == 4'hF);
`else
    stat     = 1'b0;
`endif
    obs_wren = mem_wren;
    exp_wren = w & ~in_win;
    full     = (q_model.size() == DEPTH);
    rd       = '0;
    if (stat) begin
      rd[15:8] = drops[7:0];
      rd[7:4]  = 4'(q_model.size());
      rd[1]    = full;
      rd[0]    = (q_model.size() == 0);
    end
    acc = 1'b0;
    @(posedge clock);
    if (rst) begin
      q_model.delete();
      drops = 0;
      exp_q = ref_mem[a[5:0]];
    end else begin
      pop   = (q_model.size() != 0) && r;
      exp_q = in_win ? rd : ref_mem[a[5:0]];
      if (w && in_win) begin
        if (stat) drops = 0;
        else if (!full || pop) acc = 1'b1;
        else if (drops < 255) drops++;
      end
      if (pop) q_model.delete(0);
      if (acc) q_model.push_back({a[3:0], d});
    end
    if (w && !in_win) ref_mem[a[5:0]] = d;
    #1;
    $display("txn addr=%h data=%h wren=%b ready=%b rst=%b -> valid=%b io_addr=%h io_data=%h drops=%0d q=%h",
             a, d, w, r, rst, io_valid, io_addr, io_data, drop_count, proc_q);
  endtask

  task automatic test_reset();
    repeat (70) step(12'h000, 0, 0, 0, 1);
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", io_valid); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %h want 00", drop_count); end
    checks++; if (proc_q !== exp_q) begin errors++; $display("FAIL reset_q: got %h want %h", proc_q, exp_q); end
  endtask

  task automatic test_passthrough();
    step(12'h010, 32'h1234, 1, 0, 0);
    checks++; if (obs_wren !== 1'b1) begin errors++; $display("FAIL pass_wren: got %b want 1", obs_wren); end
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL pass_valid: got %b want 0", io_valid); end
    step(12'h010, 0, 0, 0, 0);
    checks++; if (proc_q !== 32'h1234) begin errors++; $display("FAIL pass_load: got %h want 00001234", proc_q); end
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL pass_valid2: got %b want 0", io_valid); end
  endtask

  task automatic test_single_store();
    step(12'hFF3, 32'hA5, 1, 0, 0);
    checks++; if (obs_wren !== 1'b0) begin errors++; $display("FAIL single_wren: got %b want 0", obs_wren); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (io_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", i, io_valid); end
      checks++; if (io_addr !== 4'h3) begin errors++; $display("FAIL single_addr[%0d]: got %h want 3", i, io_addr); end
      checks++; if (io_data !== 32'hA5) begin errors++; $display("FAIL single_data[%0d]: got %h want a5", i, io_data); end
      if (i < 5) step(12'h020, 0, 0, 0, 0);
    end
    step(12'h020, 0, 0, 1, 0);
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", io_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) step(12'hFF0, 32'(i), 1, 0, 0);
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
    checks++; if (q_model.size() != DEPTH) begin errors++; $display("FAIL ovf_model_count: got %0d want %0d", q_model.size(), DEPTH); end
`ifdef DMEM_IO_STATUS_EN
    step(12'hFFF, 0, 0, 0, 0);
    checks++; if (proc_q !== 32'h0000_0242) begin errors++; $display("FAIL status_full: got %h want 00000242", proc_q); end
    step(12'hFFF, 32'hDEAD, 1, 0, 0);
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL status_clear: got %0d want 0", drop_count); end
    step(12'hFFF, 0, 0, 0, 0);
    checks++; if (proc_q !== 32'h0000_0042) begin errors++; $display("FAIL status_after_clear: got %h want 00000042", proc_q); end
`else
    step(12'hFF7, 0, 0, 0, 0);
    checks++; if (proc_q !== 32'h0) begin errors++; $display("FAIL window_load: got %h want 0", proc_q); end
`endif
    for (int k = 1; k <= 4; k++) begin
      checks++; if (io_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid[%0d]: got %b want 1", k, io_valid); end
      checks++; if (io_data !== 32'(k)) begin errors++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", k, io_data, 32'(k)); end
      step(12'h020, 0, 0, 1, 0);
    end
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", io_valid); end
  endtask

  task automatic test_full_push_pop();
    int          drops_before;
    logic [31:0] order [4];
    for (int i = 0; i < 4; i++) step(12'hFF0 | 12'(i), 32'(10 + i), 1, 0, 0);
    drops_before = drops;
    checks++; if (io_data !== 32'd10) begin errors++; $display("FAIL fpp_head: got %h want 0000000a", io_data); end
    step(12'hFF5, 32'd7, 1, 1, 0);
    checks++; if (drop_count !== 8'(drops_before)) begin errors++; $display("FAIL fpp_drop: got %0d want %0d", drop_count, drops_before); end
    checks++; if (q_model.size() != DEPTH) begin errors++; $display("FAIL fpp_model_count: got %0d want %0d", q_model.size(), DEPTH); end
    order = '{32'd11, 32'd12, 32'd13, 32'd7};
    for (int k = 0; k < 4; k++) begin
      checks++; if (io_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid[%0d]: got %b want 1", k, io_valid); end
      checks++; if (io_data !== order[k]) begin errors++; $display("FAIL fpp_data[%0d]: got %h want %h", k, io_data, order[k]); end
      step(12'h020, 0, 0, 1, 0);
    end
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", io_valid); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) step(12'hFF1, 32'(20 + i), 1, 0, 0);
    step(12'h020, 0, 0, 1, 0);
    checks++; if (drop_count === 8'd0) begin errors++; $display("FAIL rmd_predrop: got %0d want nonzero", drop_count); end
    step(12'hFF2, 32'h55, 1, 1, 1);
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL rmd_valid: got %b want 0", io_valid); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rmd_drop: got %0d want 0", drop_count); end
    step(12'hFF4, 32'd9, 1, 0, 0);
    checks++; if (io_valid !== 1'b1) begin errors++; $display("FAIL rmd_new_valid: got %b want 1", io_valid); end
    checks++; if (io_data !== 32'd9) begin errors++; $display("FAIL rmd_new_data: got %h want 00000009", io_data); end
    checks++; if (io_addr !== 4'h4) begin errors++; $display("FAIL rmd_new_addr: got %h want 4", io_addr); end
    step(12'h020, 0, 0, 1, 0);
    checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL rmd_sole: got %b want 0", io_valid); end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 300; i++) step(12'hFF0, 32'(i), 1, 0, 0);
    checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_drop: got %h want ff", drop_count); end
    checks++; if (io_data !== 32'd0) begin errors++; $display("FAIL sat_head: got %h want 0", io_data); end
    repeat (4) step(12'h020, 0, 0, 1, 0);
    checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", drop_count); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic        rst;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!rst && $urandom_range(0, 1) == 1) a = {8'hFF, 4'($urandom_range(0, 15))};
      else a = 12'($urandom_range(0, 63));
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), rst);
      checks++; if (obs_wren !== exp_wren) begin errors++; $display("FAIL rnd_wren[%0d]: got %b want %b", n, obs_wren, exp_wren); end
      checks++; if (io_valid !== (q_model.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, io_valid, q_model.size() != 0); end
      if (q_model.size() != 0) begin
        checks++; if ({io_addr, io_data} !== q_model[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %h want %h", n, {io_addr, io_data}, q_model[0]); end
      end
      checks++; if (drop_count !== 8'(drops)) begin errors++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", n, drop_count, drops); end
      checks++; if (proc_q !== exp_q) begin errors++; $display("FAIL rnd_q[%0d]: got %h want %h", n, proc_q, exp_q); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    test_reset();
    test_passthrough();
    test_single_store();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_drain();
    test_drop_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
